// File: rtl/master_controller.sv
// Single-master I2C bus engine: START, address, data bytes, ACK/NACK and STOP on open-drain SCL/SDA.
// Optional MASTER_CLK_STRETCH_EN: Q2 waits for the observed SCL to go high (slave clock stretching).
module master_controller #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_start,
  input  logic [6:0] cmd_addr,
  input  logic       cmd_rw,
  input  logic [7:0] cmd_count,
  input  logic [7:0] TX_data,
  input  logic       TX_fifo_empty,
  output logic       TX_read_enable_master,
  input  logic       RX_fifo_full,
  output logic [7:0] RX_data,
  output logic       RX_write_enable_master,
  input  logic       SDA_sync,
  input  logic       SCL_sync,
  output logic       SCL_out,
  output logic       SDA_out,
  output logic       busy_master,
  output logic       done,
  output logic       ack_error_set_master
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, TX_LOAD, TX_BYTE, TX_ACK,
    RX_BYTE, RX_STORE, RX_ACK, STOP, DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [7:0]    byte_cnt;
  logic          rw;
  logic          sample;
  logic          slot_state;
  logic          stretch;
  logic          q_end;
  logic          slot_end;

  // Only bit-slot states run the quarter counter; TX_LOAD/RX_STORE freeze it with SCL low.
  assign slot_state = (state == START) || (state == ADDR) || (state == ADDR_ACK) ||
                      (state == TX_BYTE) || (state == TX_ACK) || (state == RX_BYTE) ||
                      (state == RX_ACK) || (state == STOP);

`ifdef MASTER_CLK_STRETCH_EN
  assign stretch = (q == 2'd2) && (cnt == '0) && !SCL_sync;
`else
  assign stretch = 1'b0 && SCL_sync;
`endif

  assign q_end    = slot_state && !stretch && (cnt == CNT_LAST);
  assign slot_end = q_end && (q == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      q                      <= 2'd0;
      bit_cnt                <= 3'd0;
      shift                  <= 8'h00;
      byte_cnt               <= 8'h00;
      rw                     <= 1'b0;
      sample                 <= 1'b1;
      SCL_out                <= 1'b1;
      SDA_out                <= 1'b1;
      busy_master            <= 1'b0;
      done                   <= 1'b0;
      ack_error_set_master   <= 1'b0;
      TX_read_enable_master  <= 1'b0;
      RX_write_enable_master <= 1'b0;
      RX_data                <= 8'h00;
    end else begin
      TX_read_enable_master  <= 1'b0;
      RX_write_enable_master <= 1'b0;
      ack_error_set_master   <= 1'b0;
      done                   <= 1'b0;

      if (slot_state && !stretch) cnt <= q_end ? '0 : cnt + 1'b1;
      if (q_end) q <= q + 2'd1;
      if (q_end && q == 2'd1) begin
        SCL_out <= 1'b1;
        if (state == START) SDA_out <= 1'b0;
      end
      if (q_end && q == 2'd2) begin
        sample <= SDA_sync;
        if (state == RX_BYTE) shift <= {shift[6:0], SDA_sync};
        if (state == STOP) SDA_out <= 1'b1;
      end

      case (state)
        IDLE: if (cmd_start) begin
          state       <= START;
          busy_master <= 1'b1;
          shift       <= {cmd_addr, cmd_rw};
          rw          <= cmd_rw;
          byte_cnt    <= cmd_count;
          cnt         <= '0;
          q           <= 2'd0;
          bit_cnt     <= 3'd0;
          SCL_out     <= 1'b1;
          SDA_out     <= 1'b1;
        end
        START: if (slot_end) begin
          state   <= ADDR;
          SCL_out <= 1'b0;
          SDA_out <= shift[7];
          bit_cnt <= 3'd0;
        end
        ADDR, TX_BYTE: if (slot_end) begin
          SCL_out <= 1'b0;
          if (bit_cnt == 3'd7) begin
            state   <= (state == ADDR) ? ADDR_ACK : TX_ACK;
            SDA_out <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            shift   <= {shift[6:0], 1'b0};
            SDA_out <= shift[6];
          end
        end
        ADDR_ACK: if (slot_end) begin
          SCL_out <= 1'b0;
          if (sample) begin
            ack_error_set_master <= 1'b1;
            state                <= STOP;
            SDA_out              <= 1'b0;
          end else if (byte_cnt == 8'd0) begin
            state   <= STOP;
            SDA_out <= 1'b0;
          end else if (rw) begin
            state   <= RX_BYTE;
            SDA_out <= 1'b1;
            bit_cnt <= 3'd0;
          end else begin
            state <= TX_LOAD;
          end
        end
        TX_LOAD: if (!TX_fifo_empty) begin
          shift                 <= TX_data;
          TX_read_enable_master <= 1'b1;
          SDA_out               <= TX_data[7];
          bit_cnt               <= 3'd0;
          state                 <= TX_BYTE;
        end
        TX_ACK: if (slot_end) begin
          SCL_out <= 1'b0;
          if (sample) begin
            ack_error_set_master <= 1'b1;
            state                <= STOP;
            SDA_out              <= 1'b0;
          end else begin
            byte_cnt <= byte_cnt - 8'd1;
            if (byte_cnt == 8'd1) begin
              state   <= STOP;
              SDA_out <= 1'b0;
            end else begin
              state <= TX_LOAD;
            end
          end
        end
        RX_BYTE: if (slot_end) begin
          SCL_out <= 1'b0;
          if (bit_cnt != 3'd7) begin
            bit_cnt <= bit_cnt + 3'd1;
          end else if (!RX_fifo_full) begin
            RX_data                <= shift;
            RX_write_enable_master <= 1'b1;
            SDA_out                <= (byte_cnt == 8'd1);
            state                  <= RX_ACK;
          end else begin
            state <= RX_STORE;
          end
        end
        RX_STORE: if (!RX_fifo_full) begin
          RX_data                <= shift;
          RX_write_enable_master <= 1'b1;
          SDA_out                <= (byte_cnt == 8'd1);
          state                  <= RX_ACK;
        end
        RX_ACK: if (slot_end) begin
          SCL_out  <= 1'b0;
          byte_cnt <= byte_cnt - 8'd1;
          if (byte_cnt == 8'd1) begin
            state   <= STOP;
            SDA_out <= 1'b0;
          end else begin
            state   <= RX_BYTE;
            SDA_out <= 1'b1;
            bit_cnt <= 3'd0;
          end
        end
        STOP: if (slot_end) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state       <= IDLE;
          busy_master <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
